// File: rtl/shift_arbiter_if.sv
// shift_arbiter_if: request/response bus between two requesters, one consumer and shift_arbiter
interface shift_arbiter_if;
  logic        i_req_valid_0;
  logic        i_req_valid_1;
  logic        o_req_ready_0;
  logic        o_req_ready_1;
  logic [1:0]  i_req_op_0;
  logic [1:0]  i_req_op_1;
  logic [31:0] i_req_a_0;
  logic [31:0] i_req_a_1;
  logic [4:0]  i_req_shamt_0;
  logic [4:0]  i_req_shamt_1;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic        o_rsp_id;
  logic [31:0] o_rsp_data;
  logic        o_busy;
  modport master (
    output i_req_valid_0, i_req_valid_1, i_req_op_0, i_req_op_1, i_req_a_0, i_req_a_1,
           i_req_shamt_0, i_req_shamt_1, i_rsp_ready,
    input  o_req_ready_0, o_req_ready_1, o_rsp_valid, o_rsp_id, o_rsp_data, o_busy
  );
  modport slave (
    input  i_req_valid_0, i_req_valid_1, i_req_op_0, i_req_op_1, i_req_a_0, i_req_a_1,
           i_req_shamt_0, i_req_shamt_1, i_rsp_ready,
    output o_req_ready_0, o_req_ready_1, o_rsp_valid, o_rsp_id, o_rsp_data, o_busy
  );
endinterface

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbiter for two requesters feeding a multi-cycle binary-weighted shifter; SHIFT_ARB_ROR_EN turns op 11 into rotate-right instead of pass-through
module shift_arbiter (
  input logic            i_clk,
  input logic            i_rst_n,
  shift_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  mask_q, mask_d;
  logic [1:0]  op_q, op_d;
  logic        sign_q, sign_d, id_q, id_d, rr_ptr_q, rr_ptr_d;
  logic        gnt, accept;
  logic [1:0]  sel_op;
  logic [31:0] sel_a, shifted, rot;
  logic [4:0]  sel_shamt, acc_mask, step;
`ifdef SHIFT_ARB_ROR_EN
  assign rot      = (data_q >> step) | (data_q << (6'd32 - {1'b0, step}));
  assign acc_mask = sel_shamt;
`else
  assign rot      = data_q;
  assign acc_mask = (sel_op == 2'b11) ? 5'd0 : sel_shamt;
`endif
  // grant, selected request and the one-hot stage weight (value equals 2^k of the top mask bit)
  always_comb begin
    gnt       = (bus.i_req_valid_0 & bus.i_req_valid_1) ? rr_ptr_q : bus.i_req_valid_1;
    accept    = i_rst_n & (state_q == IDLE) & (bus.i_req_valid_0 | bus.i_req_valid_1);
    sel_op    = gnt ? bus.i_req_op_1 : bus.i_req_op_0;
    sel_a     = gnt ? bus.i_req_a_1 : bus.i_req_a_0;
    sel_shamt = gnt ? bus.i_req_shamt_1 : bus.i_req_shamt_0;
    step      = mask_q[4] ? 5'd16 : mask_q[3] ? 5'd8 : mask_q[2] ? 5'd4 : mask_q[1] ? 5'd2 : {4'd0, mask_q[0]};
    shifted   = (op_q == 2'b00) ? data_q << step
              : (op_q == 2'b01) ? data_q >> step
              : (op_q == 2'b10) ? (data_q >> step) | ({32{sign_q}} & ~(32'hFFFF_FFFF >> step))
              : rot;
  end
  // next state: accept in IDLE, one weighted stage per SHIFT cycle, retire in DONE
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    mask_d   = mask_q;
    op_d     = op_q;
    sign_d   = sign_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      data_d  = sel_a;
      mask_d  = acc_mask;
      op_d    = sel_op;
      sign_d  = sel_a[31];
      id_d    = gnt;
      state_d = (acc_mask == 5'd0) ? DONE : SHIFT;
    end else if (state_q == SHIFT) begin
      data_d  = shifted;
      mask_d  = mask_q & ~step;
      state_d = (mask_d == 5'd0) ? DONE : SHIFT;
    end else if (state_q == DONE && bus.i_rsp_ready) begin
      state_d  = IDLE;
      rr_ptr_d = ~id_q;
    end
  end
  // state and datapath registers; reset drops any in-flight operation
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      mask_q   <= '0;
      op_q     <= '0;
      sign_q   <= 1'b0;
      id_q     <= 1'b0;
      rr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      id_q     <= id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
  assign bus.o_req_ready_0 = accept & ~gnt;
  assign bus.o_req_ready_1 = accept & gnt;
  assign bus.o_rsp_valid   = (state_q == DONE);
  assign bus.o_rsp_id      = id_q;
  assign bus.o_rsp_data    = data_q;
  assign bus.o_busy        = (state_q != IDLE);
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed and randomized checks of shift_arbiter against a behavioural model
module tb_shift_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  shift_arbiter_if bus ();
  shift_arbiter dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  logic m_ptr = 1'b0;
  logic last_g = 1'b0;
  logic [31:0] last_data = '0;
  logic rv [2];
  logic [1:0] rop [2];
  logic [31:0] ra [2];
  logic [4:0] rsh [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [4:0] sh);
    case (op)
      2'b00: return a << sh;
      2'b01: return a >> sh;
      2'b10: return 32'($signed(a) >>> sh);
`ifdef SHIFT_ARB_ROR_EN
      default: return 32'({a, a} >> sh);
`else
      default: return a;
`endif
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [4:0] sh);
`ifdef SHIFT_ARB_ROR_EN
    return $countones(sh) + 1;
`else
    return (op == 2'b11) ? 1 : $countones(sh) + 1;
`endif
  endfunction

  task automatic apply();
    bus.i_req_valid_0 = rv[0];
    bus.i_req_valid_1 = rv[1];
    bus.i_req_op_0 = rop[0];
    bus.i_req_op_1 = rop[1];
    bus.i_req_a_0 = ra[0];
    bus.i_req_a_1 = ra[1];
    bus.i_req_shamt_0 = rsh[0];
    bus.i_req_shamt_1 = rsh[1];
  endtask

  task automatic serve(input int bp);
    logic g;
    logic [31:0] exp_d;
    int lat, n;
    apply();
    #1;
    g = (rv[0] && rv[1]) ? m_ptr : rv[1];
    chk("ready0", 32'(bus.o_req_ready_0), 32'(!g));
    chk("ready1", 32'(bus.o_req_ready_1), 32'(g));
    exp_d = ref_res(rop[g], ra[g], rsh[g]);
    lat = ref_lat(rop[g], rsh[g]);
    @(posedge clk); #1;
    n = 1;
    while (!bus.o_rsp_valid && n < 10) begin
      chk("busy_shift", 32'(bus.o_busy), 32'd1);
      chk("ready_shift", 32'({bus.o_req_ready_0, bus.o_req_ready_1}), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(lat));
    chk("data", bus.o_rsp_data, exp_d);
    chk("id", 32'(bus.o_rsp_id), 32'(g));
    chk("busy_done", 32'(bus.o_busy), 32'd1);
    repeat (bp) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(bus.o_rsp_valid), 32'd1);
      chk("bp_data", bus.o_rsp_data, exp_d);
      chk("bp_id", 32'(bus.o_rsp_id), 32'(g));
      chk("bp_ready", 32'({bus.o_req_ready_0, bus.o_req_ready_1}), 32'd0);
    end
    last_data = bus.o_rsp_data;
    bus.i_rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_rsp_ready = 1'b0;
    chk("retire_busy", 32'(bus.o_busy), 32'd0);
    chk("retire_valid", 32'(bus.o_rsp_valid), 32'd0);
    m_ptr = !g;
    last_g = g;
  endtask

  initial begin
    bus.i_rsp_ready = 1'b0;
    rv[0] = 1'b1; rv[1] = 1'b1;
    rop[0] = 2'b01; ra[0] = 32'hF000_0000; rsh[0] = 5'd4;
    rop[1] = 2'b10; ra[1] = 32'hF000_0000; rsh[1] = 5'd4;
    apply();
    #2 rst_n = 1'b0;
    #10;
    chk("rst_ready", 32'({bus.o_req_ready_0, bus.o_req_ready_1}), 32'd0);
    chk("rst_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("rst_id", 32'(bus.o_rsp_id), 32'd0);
    chk("rst_data", bus.o_rsp_data, 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    serve(0);
    chk("arb_first_id", 32'(last_g), 32'd0);
    chk("arb_first_data", last_data, 32'h0F00_0000);
    serve(0);
    chk("arb_second_id", 32'(last_g), 32'd1);
    chk("arb_second_data", last_data, 32'hFF00_0000);
    for (int i = 0; i < 4; i++) begin
      serve(0);
      chk("arb_alternate", 32'(last_g), 32'(i % 2));
    end
    rv[0] = 1'b1; rv[1] = 1'b0;
    rop[0] = 2'b10; ra[0] = 32'h8000_0000; rsh[0] = 5'd31;
    serve(0);
    chk("sra31_data", last_data, 32'hFFFF_FFFF);
    rv[0] = 1'b0; rv[1] = 1'b1;
    rop[1] = 2'b00; ra[1] = 32'h0000_0001; rsh[1] = 5'd0;
    serve(0);
    chk("sll0_data", last_data, 32'h0000_0001);
    rsh[1] = 5'd5;
    serve(0);
    chk("sll5_data", last_data, 32'h0000_0020);
    rv[1] = 1'b0; rv[0] = 1'b1;
    rop[0] = 2'b01; ra[0] = $urandom; rsh[0] = 5'($urandom);
    serve(3);
    rop[0] = 2'b00; ra[0] = 32'hDEAD_BEEF; rsh[0] = 5'd31;
    apply();
    #1;
    chk("mid_ready", 32'(bus.o_req_ready_0), 32'd1);
    @(posedge clk); #1;
    rv[0] = 1'b0;
    apply();
    @(posedge clk); #1;
    chk("mid_busy", 32'(bus.o_busy), 32'd1);
    rv[0] = 1'b1; rv[1] = 1'b1;
    apply();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'({bus.o_req_ready_0, bus.o_req_ready_1}), 32'd0);
    chk("mid_rst_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("mid_rst_id", 32'(bus.o_rsp_id), 32'd0);
    chk("mid_rst_data", bus.o_rsp_data, 32'd0);
    chk("mid_rst_busy", 32'(bus.o_busy), 32'd0);
    rv[0] = 1'b0; rv[1] = 1'b0;
    apply();
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_ptr = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      chk("mid_no_rsp", 32'({bus.o_rsp_valid, bus.o_busy}), 32'd0);
    end
    rv[0] = 1'b1; rop[0] = 2'b01; ra[0] = 32'h1234_5678; rsh[0] = 5'd7;
    serve(0);
    chk("after_rst_data", last_data, 32'h0024_68AC);
    rv[0] = 1'b1; rv[1] = 1'b0;
    rop[0] = 2'b11; ra[0] = 32'h0000_0001; rsh[0] = 5'd1;
    serve(0);
`ifdef SHIFT_ARB_ROR_EN
    chk("op3_data", last_data, 32'h8000_0000);
`else
    chk("op3_data", last_data, 32'h0000_0001);
`endif
    for (int i = 0; i < 40; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (!rv[r] || r == int'(last_g)) begin
          rv[r] = 1'($urandom);
          rop[r] = 2'($urandom);
          ra[r] = $urandom;
          rsh[r] = 5'($urandom);
        end
      end
      if (!rv[0] && !rv[1]) rv[$urandom_range(0, 1)] = 1'b1;
      serve($urandom_range(0, 2));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
